// File: rtl/pride_flag_if.sv
// Button/auto controls in, flag index and brightness out, between the UI/sync
// logic (master) and the pride flag sequencer (slave).
interface pride_flag_if;
  logic       frame_tick;
  logic       btn_next;
  logic       btn_prev;
  logic       auto_en;
  logic [3:0] flag_sel;
  logic [1:0] fade;
  logic       busy;

  modport master (
    output frame_tick, btn_next, btn_prev, auto_en,
    input  flag_sel, fade, busy
  );

  modport slave (
    input  frame_tick, btn_next, btn_prev, auto_en,
    output flag_sel, fade, busy
  );
endinterface

// File: rtl/pride_flag_sequencer.sv
// Per-frame flag scheduler: debounced next/prev buttons or a hold timer pick the
// flag, with a stepped fade-out / swap / fade-in at each change.
module pride_flag_sequencer #(
  parameter int NUM_FLAGS        = 12,
  parameter int HOLD_FRAMES      = 180,
  parameter int FADE_STEP_FRAMES = 4,
  parameter int DEBOUNCE_FRAMES  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  pride_flag_if.slave bus
);

  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int STEP_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP_FRAMES - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_FRAMES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_FRAMES - 1);
  localparam logic [3:0]        FLAG_LAST = 4'(NUM_FLAGS - 1);

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        flag_q, flag_d;
  logic [1:0]        fade_q, fade_d;
  logic              busy_q, busy_d;
  logic              dir_q, dir_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [1:0]        next_sync_q, next_sync_d;
  logic [1:0]        prev_sync_q, prev_sync_d;
  logic [DEB_W-1:0]  deb_next_q, deb_next_d;
  logic [DEB_W-1:0]  deb_prev_q, deb_prev_d;
  logic              ev_next, ev_prev, step_end, req;

  // Saturating count of consecutive high frame samples; any low sample clears it.
  function automatic logic [DEB_W-1:0] deb_update(input logic lvl, input logic [DEB_W-1:0] cnt);
    if (!lvl)            return '0;
    else if (cnt == DEB_MAX) return DEB_MAX;
    else                 return cnt + DEB_W'(1);
  endfunction

  function automatic logic [3:0] flag_step(input logic fwd, input logic [3:0] cur);
    if (fwd) return (cur == FLAG_LAST) ? 4'd0 : cur + 4'd1;
    else     return (cur == 4'd0) ? FLAG_LAST : cur - 4'd1;
  endfunction

  always_comb begin
    next_sync_d = {next_sync_q[0], bus.btn_next};
    prev_sync_d = {prev_sync_q[0], bus.btn_prev};
    deb_next_d  = deb_next_q;
    deb_prev_d  = deb_prev_q;
    state_d     = state_q;
    flag_d      = flag_q;
    fade_d      = fade_q;
    busy_d      = busy_q;
    dir_d       = dir_q;
    hold_d      = hold_q;
    step_d      = step_q;
    ev_next     = 1'b0;
    ev_prev     = 1'b0;
    req         = 1'b0;
    step_end    = (step_q == STEP_LAST);

    if (bus.frame_tick) begin
      ev_next    = next_sync_q[1] && (deb_next_q == DEB_LAST);
      ev_prev    = prev_sync_q[1] && (deb_prev_q == DEB_LAST);
      deb_next_d = deb_update(next_sync_q[1], deb_next_q);
      deb_prev_d = deb_update(prev_sync_q[1], deb_prev_q);

      unique case (state_q)
        SHOW: begin
          // Simultaneous next+prev cancel outright, including any auto request.
          if (ev_next ^ ev_prev) begin
            req   = 1'b1;
            dir_d = ev_next;
          end else if (!ev_next && bus.auto_en && hold_q == HOLD_LAST) begin
            req   = 1'b1;
            dir_d = 1'b1;
          end

          if (req) begin
            hold_d  = '0;
            step_d  = '0;
            busy_d  = 1'b1;
            state_d = FADE_OUT;
          end else if (bus.auto_en) begin
            hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + HOLD_W'(1);
          end else begin
            hold_d = '0;
          end
        end

        FADE_OUT: begin
          step_d = step_end ? '0 : step_q + STEP_W'(1);
          if (step_end) begin
            if (fade_q != 2'd0) begin
              fade_d = fade_q - 2'd1;
            end else begin
              flag_d  = flag_step(dir_q, flag_q);
              state_d = FADE_IN;
            end
          end
        end

        FADE_IN: begin
          step_d = step_end ? '0 : step_q + STEP_W'(1);
          if (step_end) begin
            fade_d = fade_q + 2'd1;
            if (fade_q == 2'd2) begin
              state_d = SHOW;
              busy_d  = 1'b0;
              hold_d  = '0;
            end
          end
        end

        default: begin
          state_d = SHOW;
          fade_d  = 2'd3;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SHOW;
      flag_q      <= 4'd0;
      fade_q      <= 2'd3;
      busy_q      <= 1'b0;
      dir_q       <= 1'b0;
      hold_q      <= '0;
      step_q      <= '0;
      next_sync_q <= 2'b00;
      prev_sync_q <= 2'b00;
      deb_next_q  <= '0;
      deb_prev_q  <= '0;
    end else begin
      state_q     <= state_d;
      flag_q      <= flag_d;
      fade_q      <= fade_d;
      busy_q      <= busy_d;
      dir_q       <= dir_d;
      hold_q      <= hold_d;
      step_q      <= step_d;
      next_sync_q <= next_sync_d;
      prev_sync_q <= prev_sync_d;
      deb_next_q  <= deb_next_d;
      deb_prev_q  <= deb_prev_d;
    end
  end

  assign bus.flag_sel = flag_q;
  assign bus.fade     = fade_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_pride_flag_sequencer.sv
// Scoreboard bench for pride_flag_sequencer: a frame-level model pushes the
// expected {flag_sel, fade, busy} per tick, popped after the DUT edge.
module tb_pride_flag_sequencer;
  localparam int NF = 4;
  localparam int HF = 5;
  localparam int FS = 2;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pride_flag_if bus ();

  pride_flag_sequencer #(
    .NUM_FLAGS(NF), .HOLD_FRAMES(HF), .FADE_STEP_FRAMES(FS), .DEBOUNCE_FRAMES(DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_no = 0;
  logic [6:0] sb_q[$];
  logic [6:0] m_last;

  int m_flag, m_fade, m_busy, m_t, m_dir, m_hold, m_runn, m_runp;
  int fade_tab[8] = '{3, 2, 1, 0, 0, 1, 2, 3};

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d)", tag, obs, exp, tick_no);
    end
  endtask

  function automatic int dut_out();
    return int'({bus.flag_sel, bus.fade, bus.busy});
  endfunction

  function automatic logic [6:0] model_out();
    return {4'(m_flag), 2'(m_fade), 1'(m_busy)};
  endfunction

  task automatic model_reset();
    m_flag = 0; m_fade = 3; m_busy = 0; m_t = 0; m_dir = 1;
    m_hold = 0; m_runn = 0; m_runp = 0;
    m_last = model_out();
  endtask

  // Frame-level behaviour: counts consecutive pressed frames and transition ticks.
  task automatic model_tick();
    bit evn, evp, req;
    int b;
    m_runn = bus.btn_next ? m_runn + 1 : 0;
    m_runp = bus.btn_prev ? m_runp + 1 : 0;
    evn = (m_runn == DB);
    evp = (m_runp == DB);
    if (m_busy == 0) begin
      req = 1'b0;
      m_hold = bus.auto_en ? m_hold + 1 : 0;
      if (evn != evp) begin
        req = 1'b1; m_dir = int'(evn);
      end else if (!evn && bus.auto_en && m_hold >= HF) begin
        req = 1'b1; m_dir = 1;
      end
      if (req) begin
        m_busy = 1; m_t = 0; m_hold = 0;
      end
      m_fade = 3;
    end else begin
      m_t++;
      b = m_t / FS;
      m_fade = fade_tab[b];
      if (b == 4 && (m_t % FS) == 0)
        m_flag = (m_dir != 0) ? (m_flag + 1) % NF : (m_flag + NF - 1) % NF;
      if (b == 7) begin
        m_busy = 0; m_hold = 0;
      end
    end
    sb_q.push_back(model_out());
  endtask

  task automatic frame();
    logic [6:0] exp;
    repeat (6) @(negedge clk);
    check_val("stable_between_ticks", dut_out(), int'(m_last));
    bus.frame_tick = 1'b1;
    tick_no++;
    model_tick();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_empty: got no entry expected one (tick %0d)", tick_no);
    end else begin
      exp = sb_q.pop_front();
      check_val("tick_outputs", dut_out(), int'(exp));
      m_last = exp;
    end
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.btn_next   = 1'b0;
    bus.btn_prev   = 1'b0;
    bus.auto_en    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("reset_values", dut_out(), int'(model_out()));
    rst_n = 1'b1;

    // Auto advance: first transition in detail, then around to wrap at 0.
    bus.auto_en = 1'b1;
    run(4);
    check_val("busy_before_tick5", int'(bus.busy), 0);
    run(1);
    check_val("busy_on_tick5", int'(bus.busy), 1);
    run(14);
    check_val("first_transition_done", dut_out(), int'({4'd1, 2'd3, 1'b0}));
    run(57);
    check_val("wrap_auto_flag", int'(bus.flag_sel), 0);

    // Auto disabled: nothing moves.
    bus.auto_en = 1'b0;
    run(50);
    check_val("auto_off_flag", dut_out(), int'({4'd0, 2'd3, 1'b0}));

    // Prev from 0 wraps to NF-1.
    bus.btn_prev = 1'b1;
    run(3);
    check_val("prev_busy_3rd_tick", int'(bus.busy), 1);
    bus.btn_prev = 1'b0;
    run(14);
    check_val("prev_wrap_flag", int'(bus.flag_sel), 3);

    // Debounce: short press ignored, 3-frame press accepted, long press once.
    bus.btn_next = 1'b1;
    run(2);
    bus.btn_next = 1'b0;
    run(5);
    check_val("short_press_ignored", dut_out(), int'({4'd3, 2'd3, 1'b0}));
    bus.btn_next = 1'b1;
    run(3);
    check_val("press3_busy", int'(bus.busy), 1);
    bus.btn_next = 1'b0;
    run(14);
    check_val("press3_flag", int'(bus.flag_sel), 0);
    bus.btn_next = 1'b1;
    run(20);
    bus.btn_next = 1'b0;
    run(5);
    check_val("long_press_once", dut_out(), int'({4'd1, 2'd3, 1'b0}));

    // Next and prev qualifying together cancel.
    bus.btn_next = 1'b1;
    bus.btn_prev = 1'b1;
    run(3);
    check_val("conflict_no_busy", int'(bus.busy), 0);
    run(2);
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    run(3);
    check_val("conflict_flag", int'(bus.flag_sel), 1);

    // Press during FADE_IN is dropped.
    bus.btn_next = 1'b1;
    run(3);
    bus.btn_next = 1'b0;
    run(9);
    bus.btn_next = 1'b1;
    run(3);
    bus.btn_next = 1'b0;
    run(13);
    check_val("fadein_press_dropped", dut_out(), int'({4'd2, 2'd3, 1'b0}));

    // Dropping auto_en mid-transition lets it finish, then holds.
    bus.auto_en = 1'b1;
    run(8);
    bus.auto_en = 1'b0;
    run(30);
    check_val("auto_drop_complete", dut_out(), int'({4'd3, 2'd3, 1'b0}));

    // Asynchronous reset in the middle of FADE_OUT.
    bus.auto_en = 1'b1;
    run(8);
    check_val("midfade_busy", int'(bus.busy), 1);
    check_val("midfade_fade", int'(bus.fade), 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    sb_q.delete();
    check_val("async_reset_immediate", dut_out(), int'({4'd0, 2'd3, 1'b0}));
    bus.auto_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_val("post_reset_idle", dut_out(), int'(model_out()));
    run(5);
    check_val("post_reset_ticks", dut_out(), int'({4'd0, 2'd3, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
